argmax_classifier: RTL and testbench

//   Downstream stage of the vector-matrix product: takes the N per-class dot-product scores in parallel and scans them sequentially.

---
 rtl/argmax_classifier.sv | 191 +++++++++++++++++++
 tb/tb_argmax_classifier.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/argmax_classifier.sv
// rtl/argmax_classifier.sv - sequential argmax over N signed class scores
//
// Purpose:
//   Takes a vector of N signed per-class scores in one handshake, copies it
//   into an internal register and scans it one score per cycle.
//   It reports the index of the largest score and that score.
//   Ties resolve to the lowest index.
//   Both sides use valid/ready so the producer and consumer may stall.
//
// Optional feature macro: ARGMAX_MARGIN_EN
//   When defined, a runner-up score is tracked.
//   The margin port (best minus runner-up, unsigned) is added.
//
// Ports:
//   clk          rising-edge clock
//   GlobalReset  asynchronous reset, active-low
//   in_valid     score vector valid
//   in_ready     block can accept a vector (registered)
//   values       N packed scores, score k at values[(k+1)*VALUE_SIZE-1 -: VALUE_SIZE]
//   out_valid    result valid (registered)
//   out_ready    consumer accepts result
//   class_idx    index of the maximum score
//   max_value    maximum score, signed
//   margin       best minus runner-up, VALUE_SIZE+1 bits (ARGMAX_MARGIN_EN only)
module argmax_classifier #(
  parameter int N          = 10,
  parameter int VALUE_SIZE = 26,
  parameter int IDX_SIZE   = 4
) (
  input  logic                         clk,
  input  logic                         GlobalReset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N*VALUE_SIZE-1:0]      values,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [IDX_SIZE-1:0]          class_idx,
  output logic signed [VALUE_SIZE-1:0] max_value
`ifdef ARGMAX_MARGIN_EN
  ,
  output logic [VALUE_SIZE:0]          margin
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [IDX_SIZE-1:0] LAST_IDX = IDX_SIZE'(N - 1);

  state_t                       state_q, state_d;
  logic [N*VALUE_SIZE-1:0]      vec_q, vec_d;
  logic signed [VALUE_SIZE-1:0] best_q, best_d;
  logic [IDX_SIZE-1:0]          idx_q, idx_d;
  logic [IDX_SIZE-1:0]          cnt_q, cnt_d;
  logic signed [VALUE_SIZE-1:0] cur;

  logic                         in_ready_d;
  logic                         out_valid_d;
  logic [IDX_SIZE-1:0]          class_idx_d;
  logic signed [VALUE_SIZE-1:0] max_value_d;

`ifdef ARGMAX_MARGIN_EN
  localparam logic signed [VALUE_SIZE-1:0] MOST_NEG = {1'b1, {(VALUE_SIZE-1){1'b0}}};

  logic signed [VALUE_SIZE-1:0] second_q, second_d;
  logic [VALUE_SIZE:0]          margin_d;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    best_d      = best_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready;
    out_valid_d = out_valid;
    class_idx_d = class_idx;
    max_value_d = max_value;
`ifdef ARGMAX_MARGIN_EN
    second_d    = second_q;
    margin_d    = margin;
`endif
    // Score currently under comparison, taken from the internal copy so the
    // producer is free to change values after the accept edge.
    cur = vec_q[int'(cnt_q)*VALUE_SIZE +: VALUE_SIZE];

    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready) begin
          vec_d      = values;
          best_d     = values[VALUE_SIZE-1:0];
          idx_d      = '0;
          cnt_d      = IDX_SIZE'(1);
          in_ready_d = 1'b0;
`ifdef ARGMAX_MARGIN_EN
          second_d   = MOST_NEG;
`endif
          state_d    = (N > 1) ? SCAN : DONE;
        end
      end

      SCAN: begin
        // Strictly greater only, so a tie keeps the earlier (lower) index.
        if (cur > best_q) begin
          best_d   = cur;
          idx_d    = cnt_q;
`ifdef ARGMAX_MARGIN_EN
          second_d = best_q;
`endif
        end
`ifdef ARGMAX_MARGIN_EN
        else if (cur > second_q) begin
          second_d = cur;
        end
`endif
        // Stop at the last score instead of incrementing, so cnt never wraps
        // even when N equals 2**IDX_SIZE.
        if (cnt_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + IDX_SIZE'(1);
        end
      end

      DONE: begin
        // First DONE cycle publishes the result; afterwards the outputs hold
        // until the consumer takes them.
        if (!out_valid) begin
          out_valid_d = 1'b1;
          class_idx_d = idx_q;
          max_value_d = best_q;
`ifdef ARGMAX_MARGIN_EN
          // With a single score there is no runner-up; report zero margin.
          if (N == 1) begin
            margin_d = '0;
          end else begin
            margin_d = {best_q[VALUE_SIZE-1], best_q} - {second_q[VALUE_SIZE-1], second_q};
          end
`endif
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      state_q   <= IDLE;
      vec_q     <= '0;
      best_q    <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      class_idx <= '0;
      max_value <= '0;
`ifdef ARGMAX_MARGIN_EN
      second_q  <= '0;
      margin    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      best_q    <= best_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      class_idx <= class_idx_d;
      max_value <= max_value_d;
`ifdef ARGMAX_MARGIN_EN
      second_q  <= second_d;
      margin    <= margin_d;
`endif
    end
  end

endmodule

// File: tb/tb_argmax_classifier.sv
// tb/tb_argmax_classifier.sv - scoreboard bench for argmax_classifier (N=10 and N=1 instances)
module tb_argmax_classifier;

  localparam int N  = 10;
  localparam int VS = 26;
  localparam int IW = 4;
  localparam int MINV = -33554432;
  localparam int MAXV = 33554431;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // N=10 instance
  logic                 in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic [N*VS-1:0]      values_a;
  logic [IW-1:0]        class_idx_a;
  logic signed [VS-1:0] max_value_a;
  // N=1 instance
  logic                 in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [VS-1:0]        values_b;
  logic [0:0]           class_idx_b;
  logic signed [VS-1:0] max_value_b;
`ifdef ARGMAX_MARGIN_EN
  logic [VS:0]          margin_a, margin_b;
`endif

  argmax_classifier #(.N(N), .VALUE_SIZE(VS), .IDX_SIZE(IW)) dut_a (
    .clk(clk), .GlobalReset(rst_n),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .values(values_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a),
    .class_idx(class_idx_a), .max_value(max_value_a)
`ifdef ARGMAX_MARGIN_EN
    , .margin(margin_a)
`endif
  );

  argmax_classifier #(.N(1), .VALUE_SIZE(VS), .IDX_SIZE(1)) dut_b (
    .clk(clk), .GlobalReset(rst_n),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .values(values_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .class_idx(class_idx_b), .max_value(max_value_b)
`ifdef ARGMAX_MARGIN_EN
    , .margin(margin_b)
`endif
  );

  typedef struct {
    int idx;
    int val;
    int mar;
    int tag;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [N*VS-1:0] pack(input int s [N]);
    logic [N*VS-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[k*VS +: VS] = s[k][VS-1:0];
    return v;
  endfunction

  // Monitors: check latency on the rising edge of out_valid, pop and compare
  // on every handshake.
  logic prev_a = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_a = 1'b0;
    end else begin
      if (out_valid_a && !prev_a) begin
        if (qa.size() == 0) chk("a_unexpected_valid", 1, 0);
        else chk("a_latency", cyc - qa[0].tag, N);
      end
      if (out_valid_a && out_ready_a && qa.size() != 0) begin
        ea = qa.pop_front();
        chk("a_class_idx", longint'(class_idx_a), ea.idx);
        chk("a_max_value", longint'(max_value_a), ea.val);
`ifdef ARGMAX_MARGIN_EN
        chk("a_margin", longint'(margin_a), ea.mar);
`endif
      end
      prev_a = out_valid_a;
    end
  end

  logic prev_b = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_b = 1'b0;
    end else begin
      if (out_valid_b && !prev_b) begin
        if (qb.size() == 0) chk("b_unexpected_valid", 1, 0);
        else chk("b_latency", cyc - qb[0].tag, 1);
      end
      if (out_valid_b && out_ready_b && qb.size() != 0) begin
        eb = qb.pop_front();
        chk("b_class_idx", longint'(class_idx_b), eb.idx);
        chk("b_max_value", longint'(max_value_b), eb.val);
`ifdef ARGMAX_MARGIN_EN
        chk("b_margin", longint'(margin_b), eb.mar);
`endif
      end
      prev_b = out_valid_b;
    end
  end

  task automatic send_a(input logic [N*VS-1:0] vec, input int ei, input int ev, input int em,
                        input bit hold, output int tag);
    bit ok;
    ok = 1'b0;
    in_valid_a = 1'b1;
    values_a   = vec;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready_a) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    tag = cyc;
    if (!ok) chk("a_accept_timeout", 0, 1);
    else qa.push_back('{ei, ev, em, tag});
    if (!hold) in_valid_a = 1'b0;
  endtask

  task automatic send_b(input int score, input int ev);
    bit ok;
    ok = 1'b0;
    in_valid_b = 1'b1;
    values_b   = score[VS-1:0];
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready_b) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!ok) chk("b_accept_timeout", 0, 1);
    else qb.push_back('{0, ev, 0, cyc});
    in_valid_b = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (qa.size() == 0 && qb.size() == 0 && !out_valid_a && !out_valid_b) break;
    end
    chk("drain_a", qa.size(), 0);
    chk("drain_b", qb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  int sv [N];
  int t1, t2;
  bit seen;

  initial begin
    rst_n = 1'b0;
    in_valid_a = 1'b0; out_ready_a = 1'b1; values_a = '0;
    in_valid_b = 1'b0; out_ready_b = 1'b1; values_b = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready_a, 0);
    chk("rst_out_valid", out_valid_a, 0);
    chk("rst_class_idx", class_idx_a, 0);
    chk("rst_max_value", longint'(max_value_a), 0);
`ifdef ARGMAX_MARGIN_EN
    chk("rst_margin", margin_a, 0);
`endif
    chk("rst_in_ready_b", in_ready_b, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_before_first_edge", in_ready_a, 0);
    @(negedge clk);
    chk("in_ready_after_first_edge", in_ready_a, 1);
    @(posedge clk);
    #1;

    // 1: mixed scores, tie at 100 keeps index 2
    sv = '{5, -3, 100, 7, 100, 0, -1, 2, 99, 4};
    send_a(pack(sv), 2, 100, 0, 1'b0, t1);
    wait_drain();

    // 2: all most-negative, then one step above at index 9, then full range
    sv = '{MINV, MINV, MINV, MINV, MINV, MINV, MINV, MINV, MINV, MINV};
    send_a(pack(sv), 0, MINV, 0, 1'b0, t1);
    sv[9] = MINV + 1;
    send_a(pack(sv), 9, MINV + 1, 1, 1'b0, t1);
    sv = '{MINV, MAXV, MINV, MINV, MINV, MINV, MINV, MINV, MINV, MINV};
    send_a(pack(sv), 1, MAXV, 67108863, 1'b0, t1);
    wait_drain();

    // 3: backpressure for 20 cycles with in_valid asserted
    out_ready_a = 1'b0;
    sv = '{-5, -6, -7, -8, -9, -10, -11, -12, -13, -2};
    send_a(pack(sv), 9, -2, 3, 1'b0, t1);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid_a) begin
        seen = 1'b1;
        break;
      end
    end
    chk("bp_out_valid_seen", seen, 1);
    @(posedge clk);
    #1;
    in_valid_a = 1'b1;
    sv = '{50, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    values_a = pack(sv);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid_a, 1);
      chk("bp_in_ready", in_ready_a, 0);
      chk("bp_class_idx", class_idx_a, 9);
      chk("bp_max_value", longint'(max_value_a), -2);
    end
    @(posedge clk);
    #1;
    in_valid_a = 1'b0;
    out_ready_a = 1'b1;
    @(posedge clk);
    #1;
    out_ready_a = 1'b0;
    @(negedge clk);
    chk("bp_release_in_ready", in_ready_a, 1);
    chk("bp_release_out_valid", out_valid_a, 0);
    @(posedge clk);
    #1;
    out_ready_a = 1'b1;
    wait_drain();

    // 4: back-to-back vectors, accepts spaced N+2 cycles
    sv = '{10, 20, 30, 40, 50, 60, 70, 80, 90, 95};
    send_a(pack(sv), 9, 95, 5, 1'b1, t1);
    sv = '{1000, -1000, 999, 0, 0, 0, 0, 0, 0, 0};
    send_a(pack(sv), 0, 1000, 1, 1'b0, t2);
    chk("b2b_spacing", t2 - t1, N + 2);
    wait_drain();

    // 5: reset mid-scan aborts, then a fresh vector
    sv = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
    send_a(pack(sv), 5, 9, 3, 1'b0, t1);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    qa.delete();
    #1;
    chk("abort_out_valid", out_valid_a, 0);
    chk("abort_in_ready", in_ready_a, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_in_ready_pre", in_ready_a, 0);
    @(negedge clk);
    chk("abort_in_ready_post", in_ready_a, 1);
    @(posedge clk);
    #1;
    sv = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    send_a(pack(sv), 6, 1, 1, 1'b0, t1);
    wait_drain();

    // 6: single-score instance
    send_b(-7, -7);
    send_b(MAXV, MAXV);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
